// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the sequential instruction memory.
// Optional parity storage is enabled with INSTR_MEM_PARITY_EN.
package instr_mem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int NOP_W = 12;
    localparam logic [NOP_W-1:0] NOP = '0;

    // Even parity over a zero-extended word; callers cast their data to 64 bits.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/instr_mem_seq_if.sv
// Fetch, decode-side and program-load signals of the instruction memory.
// The master modport is the fetch/load driver; the slave modport is the memory.
interface instr_mem_seq_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ready;
    logic              instr_err;
    logic              instr_perr;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    logic              init_done;

    modport master (
        output fetch_req, fetch_addr, instr_ready, ld_en, ld_addr, ld_data,
        input  fetch_ready, instr_valid, instr_data, instr_addr, instr_err,
               instr_perr, ld_ack, init_done
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_ready, ld_en, ld_addr, ld_data,
        output fetch_ready, instr_valid, instr_data, instr_addr, instr_err,
               instr_perr, ld_ack, init_done
    );
endinterface

// File: rtl/instr_mem_array.sv
// 1R1W synchronous read-first RAM; the read register resets to zero and
// returns zero for addresses beyond DEPTH.
module instr_mem_array #(
    parameter int W      = 12,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Non-blocking read of the pre-edge contents gives read-first behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
        end
    end
endmodule

// File: rtl/instr_mem_seq.sv
// Synchronous-read instruction memory with fetch handshake, load port and
// post-reset NOP clear. Define INSTR_MEM_PARITY_EN to store a parity bit per word.
module instr_mem_seq
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input logic            clk,
    input logic            rst,
    instr_mem_seq_if.slave bus
);
`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              vld_p1;
    logic              err_p1;
    logic              ack_p1;
    logic              done;
    logic [ADDR_W-1:0] addr_p1;
    logic              frdy;
    logic              accept;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [MEM_W-1:0]  wdata;
    logic [MEM_W-1:0]  rdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign frdy   = (state == ST_RUN) && (!vld_p1 || bus.instr_ready);
    assign accept = bus.fetch_req && frdy;

    // Clear sequence owns the write port during INIT; loads only in RUN.
    always_comb begin
        we    = 1'b0;
        waddr = cnt;
        wdata = MEM_W'(NOP);
        if (state == ST_INIT) begin
            we = 1'b1;
        end else if (bus.ld_en && in_range(bus.ld_addr)) begin
            we    = 1'b1;
            waddr = bus.ld_addr;
`ifdef INSTR_MEM_PARITY_EN
            wdata = {even_parity(64'(bus.ld_data)), bus.ld_data};
`else
            wdata = bus.ld_data;
`endif
        end
    end

    instr_mem_array #(
        .W      (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (accept),
        .raddr (bus.fetch_addr),
        .rdata (rdata)
    );

    // p0 -> p1: accepted fetch becomes the output word one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            cnt     <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            ack_p1  <= 1'b0;
            done    <= 1'b0;
            addr_p1 <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        done  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ack_p1 <= bus.ld_en;
                    if (accept) begin
                        vld_p1  <= 1'b1;
                        addr_p1 <= bus.fetch_addr;
                        err_p1  <= !in_range(bus.fetch_addr);
                    end else if (bus.instr_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.fetch_ready = frdy;
    assign bus.instr_valid = vld_p1;
    assign bus.instr_data  = rdata[DATA_W-1:0];
    assign bus.instr_addr  = addr_p1;
    assign bus.instr_err   = err_p1;
    assign bus.ld_ack      = ack_p1;
    assign bus.init_done   = done;
`ifdef INSTR_MEM_PARITY_EN
    assign bus.instr_perr  = rdata[DATA_W] ^ even_parity(64'(rdata[DATA_W-1:0]));
`else
    assign bus.instr_perr  = 1'b0;
`endif
endmodule

// File: doc/instr_mem_seq.md
Name: instr_mem_seq

Overview:
- Parametrised, synchronous-read successor to the combinational instruction ROM.
- Sits between the fetch stage and the decode stage.
- Fetch side: request/valid handshake with one-cycle read latency and output hold under back-pressure.
- Adds a word-write load port for program download and a post-reset clear sequence that fills memory with NOP (all zeros).

Parameters:
- DATA_W, 12, instruction width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready
- instr_valid  out  1  instr_data/instr_addr valid
- instr_data  out  DATA_W  fetched instruction
- instr_addr  out  ADDR_W  address of the word in instr_data
- instr_ready  in  1  consumer accepts when instr_valid && instr_ready
- instr_err  out  1  qualifies instr_valid; set for an out-of-range address
- instr_perr  out  1  parity error flag, qualifies instr_valid (see Optional Feature)
- ld_en  in  1  load write strobe
- ld_addr  in  ADDR_W  load address
- ld_data  in  DATA_W  load data
- ld_ack  out  1  one-cycle pulse, the cycle after an accepted load
- init_done  out  1  high once the clear sequence finishes

Behaviour:
- Reset, asynchronous: state=INIT, clear counter=0, instr_valid=0, instr_data=0, instr_addr=0, instr_err=0, instr_perr=0, ld_ack=0, init_done=0, fetch_ready=0.
- Reset mid-operation: in-flight fetch is discarded; load is lost; INIT restarts from word 0.
- FSM INIT:
  - Writes 0 to mem[cnt] each cycle; cnt increments.
  - After cnt==DEPTH-1 is written, moves to RUN and init_done=1; INIT lasts exactly DEPTH cycles.
  - fetch_ready=0 throughout; ld_en is ignored (no ld_ack).
- FSM RUN: terminal state until reset.
  - fetch_ready = !instr_valid || instr_ready (single-stage pipeline, full throughput).
- Fetch:
  - Accepted at edge N; at edge N+1, instr_valid=1, instr_data=mem[fetch_addr], instr_addr=fetch_addr.
  - Back-pressure: while instr_valid && !instr_ready, instr_data/instr_addr/instr_err/instr_perr are held stable.
  - Drain: instr_valid drops after a handshake with no new accept.
  - Consume-and-issue: consume and new accept in the same cycle gives back-to-back valid words.
- Out of range (fetch_addr >= DEPTH): instr_data=0 (NOP), instr_err=1 with instr_valid. For the load port, the write is dropped but ld_ack still pulses.
- Load (RUN only):
  - ld_en writes mem[ld_addr]=ld_data at the edge; ld_ack=1 the next cycle.
  - No handshake; loads are always accepted and take priority over nothing (separate write port).
- Same-address conflict: a fetch accepted in the same cycle as a load to that address returns the OLD word (read-first). A fetch one cycle later returns the new word.
- Widths: address compare is done at ADDR_W bits; no wrap-around; addresses are never truncated to log2(DEPTH).

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on load and stored as 0 by INIT.
  - On fetch, instr_perr = stored parity XOR reduction-XOR(data); held with the data.
  - Out-of-range fetch gives instr_perr=0.
- Undefined: no parity storage; instr_perr tied 0. The port exists in both builds.

Decomposition:
- Package instr_mem_pkg:
  - FSM state enum (ST_INIT, ST_RUN)
  - NOP constant (all zeros, DATA_W wide)
  - Parity helper function
- One sub-module: instr_mem_array, a 1R1W synchronous read-first RAM holding DATA_W(+1) bits.
- FSM, handshake and load logic stay in the top module.

Test Plan:
- Reset release -> fetch_ready=0 and init_done=0 for exactly 256 cycles, then both =1. A subsequent fetch of 0x3F returns 12'h000, err=0.
- Load 0x05<-12'hABC, then fetch 0x05 -> ld_ack pulse one cycle after load; instr_valid next cycle with data 12'hABC, addr 0x05.
- Back-to-back fetches 0x00..0x03 with instr_ready=1 -> four consecutive valid cycles, data in order. Then hold instr_ready=0 for 3 cycles: data frozen, fetch_ready=0.
- Same-cycle load 0x10<-12'h111 (old value 12'h222) and fetch 0x10 -> returns 12'h222; a re-fetch returns 12'h111.
- DEPTH=200 build: fetch 0xD0 -> data 0, instr_err=1. Load to 0xD0 -> ld_ack pulses, memory unchanged.
- Assert rst mid-fetch with instr_valid=1 -> all outputs clear immediately (async); INIT reruns and previously loaded words read 0. With INSTR_MEM_PARITY_EN, a forced flipped array bit gives instr_perr=1.
